// File: rtl/ahb_wait_mem.sv
// AHB-Lite word memory slave with a programmable number of wait states per OKAY
// data phase, two-cycle ERROR responses and DMAC byte-lane strobes.
module ahb_wait_mem #(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic        HREADYIN,
  input  logic [31:0] HWDATA,
  input  logic [3:0]  MWStrb,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t        state, state_next;
  logic [2:0]    cnt, cnt_next;
  logic          active, active_next;
  logic [AW-1:0] cap_idx;
  logic [1:0]    cap_lo;
  logic [1:0]    cap_size;
  logic          cap_write;

  logic [31:0]   mem [0:MEM_DEPTH-1];

  logic          accept;
  logic          addr_err;
  logic          commit;
  logic [3:0]    lanes;
  logic          unused_bits;

  assign unused_bits = ^{HADDR[31:12], HTRANS[0]};

  // Only sample while this slave is itself ready, so a misbehaving HREADYIN
  // can never overwrite the fields of a data phase still in progress.
  assign accept = HSEL && HREADYIN && HTRANS[1] && HREADYOUT;

  always_comb begin
    addr_err = 1'b0;
    if (HSIZE > 3'd2)                         addr_err = 1'b1;
    if (HSIZE == 3'd1 && HADDR[0])            addr_err = 1'b1;
    if (HSIZE == 3'd2 && HADDR[1:0] != 2'b00) addr_err = 1'b1;
    if ({22'd0, HADDR[11:2]} >= 32'(MEM_DEPTH)) addr_err = 1'b1;
  end

  // NOTE: every output of this block is assigned a default first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    active_next = active;
    case (state)
      WAIT: begin
        if (cnt == 3'd0) state_next = IDLE;
        else             cnt_next   = cnt - 3'd1;
      end
      ERR1: state_next = ERR2;
      default: begin
        // IDLE and ERR2 both end any current data phase on this edge.
        state_next  = IDLE;
        active_next = 1'b0;
        cnt_next    = 3'd0;
        if (accept) begin
          if (addr_err) begin
            state_next = ERR1;
          end else begin
            active_next = 1'b1;
            if (WAIT_STATES > 0) begin
              state_next = WAIT;
              cnt_next   = 3'(WAIT_STATES - 1);
            end
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      active    <= 1'b0;
      cap_idx   <= '0;
      cap_lo    <= 2'b00;
      cap_size  <= 2'b00;
      cap_write <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      active <= active_next;
      if (accept) begin
        cap_idx   <= HADDR[AW+1:2];
        cap_lo    <= HADDR[1:0];
        cap_size  <= HSIZE[1:0];
        cap_write <= HWRITE;
      end
    end
  end

  assign HREADYOUT = !(state == WAIT || state == ERR1);
  assign HRESP     = (state == ERR1 || state == ERR2) ? 2'b01 : 2'b00;
  assign HRDATA    = (active && !cap_write) ? mem[cap_idx] : 32'd0;

  // The final ready-high cycle of an OKAY transfer is always spent in IDLE.
  assign commit = active && cap_write && (state == IDLE);

  always_comb begin
    lanes = MWStrb;
    if (MWStrb == 4'b0000) begin
      case (cap_size)
        2'd0:    lanes = 4'b0001 << cap_lo;
        2'd1:    lanes = cap_lo[1] ? 4'b1100 : 4'b0011;
        default: lanes = 4'b1111;
      endcase
    end
  end

  // NOTE: the array has no reset; contents survive HRESET and it maps onto RAM.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (lanes[i]) mem[cap_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_wait_mem.sv
// Scoreboard bench for ahb_wait_mem: one instance with one wait state, one with
// none; a negedge monitor retires every data phase against a queue of expectations.
module tb_ahb_wait_mem;

  localparam logic [2:0] BYTE = 3'b000;
  localparam logic [2:0] HALF = 3'b001;
  localparam logic [2:0] WORD = 3'b010;
  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          waits;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel  = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = T_IDLE;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize  = WORD;
  logic [31:0] hwdata = '0;
  logic [3:0]  mwstrb = '0;
  logic        sel    = 1'b1;   // 1: one-wait-state instance, 0: zero-wait instance

  logic [31:0] rdata1, rdata0, bus_rdata;
  logic        ready1, ready0, bus_ready;
  logic [1:0]  resp1, resp0, bus_resp;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus_ready = sel ? ready1 : ready0;
  assign bus_resp  = sel ? resp1  : resp0;
  assign bus_rdata = sel ? rdata1 : rdata0;

  ahb_wait_mem #(.MEM_DEPTH(256), .WAIT_STATES(1)) dut1 (
    .HCLK(clk), .HRESET(rst_n), .HSEL(hsel & sel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADYIN(bus_ready), .HWDATA(hwdata),
    .MWStrb(mwstrb), .HRDATA(rdata1), .HREADYOUT(ready1), .HRESP(resp1)
  );

  ahb_wait_mem #(.MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst_n), .HSEL(hsel & ~sel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HREADYIN(bus_ready), .HWDATA(hwdata),
    .MWStrb(mwstrb), .HRDATA(rdata0), .HREADYOUT(ready0), .HRESP(resp0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Monitor: every cycle with HREADYOUT high ends the current data phase.
  bit   dphase = 1'b0;
  int   waits  = 0;
  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      dphase = 1'b0;
      waits  = 0;
    end else if (dphase && !bus_ready) begin
      waits++;
      if (exp_q.size() > 0) check("resp_in_wait", 32'(bus_resp), 32'(exp_q[0].resp));
    end else begin
      if (dphase) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("resp", 32'(bus_resp), 32'(e.resp));
          check("wait_cycles", 32'(waits), 32'(e.waits));
          check("rdata", bus_rdata, e.rdata);
        end
      end
      dphase = hsel && htrans[1];
      waits  = 0;
    end
  end

  // Presents one address phase, holds it until accepted, then drives its data phase.
  task automatic issue(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       input logic [31:0] want_rdata, input logic err,
                       input logic [1:0] trans = T_NONSEQ);
    logic r;
    int   budget;
    exp_t x;
    hsel = 1'b1; haddr = addr; htrans = trans; hwrite = wr; hsize = size;
    budget = 0;
    do begin
      @(negedge clk);
      r = bus_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!r && budget < 50);
    check("accept", 32'(r), 32'd1);
    acc_cyc = cyc;
    hwdata  = wdata;
    mwstrb  = strb;
    x.rdata = (wr || err) ? 32'd0 : want_rdata;
    x.resp  = err ? 2'b01 : 2'b00;
    x.waits = err ? 1 : (sel ? 1 : 0);
    exp_q.push_back(x);
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0;
    for (int n = 0; n < 20 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check("sb_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready1", 32'(ready1), 32'd1);
    check("rst_resp1",  32'(resp1),  32'd0);
    check("rst_rdata1", rdata1,      32'd0);
    check("rst_ready0", 32'(ready0), 32'd1);
    check("rst_resp0",  32'(resp0),  32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // One wait state: back-to-back write then read of the same word.
    issue(32'h000, 1'b1, WORD, 32'hAABBCCDD, 4'b1111, 32'd0, 1'b0);
    issue(32'h000, 1'b0, WORD, 32'd0, 4'b0000, 32'hAABBCCDD, 1'b0);
    // Strobed byte lane into a preloaded word.
    issue(32'h004, 1'b1, WORD, 32'h11223344, 4'b1111, 32'd0, 1'b0);
    issue(32'h005, 1'b1, BYTE, 32'h0000EE00, 4'b0010, 32'd0, 1'b0);
    issue(32'h004, 1'b0, WORD, 32'd0, 4'b0000, 32'h1122EE44, 1'b0);
    // Lanes derived from size and address when strobes are zero.
    issue(32'h008, 1'b1, WORD, 32'h00000000, 4'b1111, 32'd0, 1'b0);
    issue(32'h00A, 1'b1, HALF, 32'h55660000, 4'b0000, 32'd0, 1'b0);
    issue(32'h008, 1'b0, WORD, 32'd0, 4'b0000, 32'h55660000, 1'b0);
    issue(32'h00C, 1'b1, WORD, 32'h00000000, 4'b1111, 32'd0, 1'b0);
    issue(32'h00D, 1'b1, BYTE, 32'h00007700, 4'b0000, 32'd0, 1'b0);
    issue(32'h00C, 1'b0, WORD, 32'd0, 4'b0000, 32'h00007700, 1'b0);
    // Error responses, each accepted during the previous ERR2 cycle.
    issue(32'h002, 1'b1, WORD, 32'hFFFFFFFF, 4'b1111, 32'd0, 1'b1);
    issue(32'h400, 1'b1, WORD, 32'hFFFFFFFF, 4'b1111, 32'd0, 1'b1);
    issue(32'h001, 1'b1, HALF, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b1);
    issue(32'h000, 1'b0, 3'b011, 32'd0, 4'b0000, 32'd0, 1'b1);
    issue(32'h000, 1'b0, WORD, 32'd0, 4'b0000, 32'hAABBCCDD, 1'b0);
    idle();

    // BUSY, IDLE and deselected cycles give zero-wait OKAY.
    hsel = 1'b1; htrans = T_BUSY; haddr = 32'h004;
    @(negedge clk);
    check("busy_ready", 32'(bus_ready), 32'd1);
    check("busy_resp",  32'(bus_resp),  32'd0);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = T_NONSEQ;
    @(negedge clk);
    check("unsel_ready", 32'(bus_ready), 32'd1);
    check("unsel_rdata", bus_rdata,      32'd0);
    @(posedge clk); #1;
    idle();

    // Reset in the middle of a write's wait state aborts the write.
    issue(32'h010, 1'b1, WORD, 32'h12345678, 4'b1111, 32'd0, 1'b0);
    idle();
    hsel = 1'b1; haddr = 32'h010; htrans = T_NONSEQ; hwrite = 1'b1; hsize = WORD;
    @(posedge clk); #1;
    hwdata = 32'hDEADBEEF; mwstrb = 4'b1111;
    hsel = 1'b0; htrans = T_IDLE;
    @(negedge clk);
    check("abort_wait_low", 32'(bus_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(bus_ready), 32'd1);
    check("abort_resp",  32'(bus_resp),  32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    issue(32'h010, 1'b0, WORD, 32'd0, 4'b0000, 32'h12345678, 1'b0);
    idle();

    // Zero wait states: 10-beat write burst then 10-beat read burst.
    sel = 1'b0;
    @(posedge clk); #1;
    t0 = 0;
    for (int i = 0; i < 10; i++) begin
      issue(32'(i * 4), 1'b1, WORD, 32'hC0DE0000 + 32'(i), 4'b1111, 32'd0, 1'b0,
            (i == 0) ? T_NONSEQ : T_SEQ);
      if (i == 0) t0 = acc_cyc;
    end
    check("wr_burst_cycles", 32'(acc_cyc - t0), 32'd9);
    for (int i = 0; i < 10; i++) begin
      issue(32'(i * 4), 1'b0, WORD, 32'd0, 4'b0000, 32'hC0DE0000 + 32'(i), 1'b0,
            (i == 0) ? T_NONSEQ : T_SEQ);
      if (i == 0) t0 = acc_cyc;
    end
    check("rd_burst_cycles", 32'(acc_cyc - t0), 32'd9);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
